// File: rtl/vdu_pkg.sv
// vdu_pkg: default 640x480 capture timing, sync polarity and lock FSM states
package vdu_pkg;
    localparam logic DEF_SYNC_POL = 1'b0;
    localparam int   DEF_H_ACTIVE = 640;
    localparam int   DEF_V_ACTIVE = 480;
    localparam int   DEF_H_START  = 144;
    localparam int   DEF_V_START  = 35;
    typedef enum logic [1:0] {UNLOCKED, TRACK, LOCKED} lock_state_t;
endpackage

// File: rtl/vdu_sync_meas.sv
// vdu_sync_meas: registers the video inputs, finds sync assert edges, tracks hpos/vpos and line/frame totals
// ports: vdu_clk/vdu_rst; red/green/blue/horiz_sync/vert_sync raw inputs;
//        rgb registered colour; hs_edge/vs_edge assert edges; hpos/vpos current position;
//        h_meas/v_meas period/line count ending now; h_total/v_total last measured totals
module vdu_sync_meas import vdu_pkg::*; #(
    parameter logic SYNC_POL = DEF_SYNC_POL,
    parameter int   CNT_W    = 10
) (
    input  logic             vdu_clk,
    input  logic             vdu_rst,
    input  logic             red,
    input  logic             green,
    input  logic             blue,
    input  logic             horiz_sync,
    input  logic             vert_sync,
    output logic [2:0]       rgb,
    output logic             hs_edge,
    output logic             vs_edge,
    output logic [CNT_W-1:0] hpos,
    output logic [CNT_W-1:0] vpos,
    output logic [CNT_W-1:0] h_meas,
    output logic [CNT_W-1:0] v_meas,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] v_total
);
    logic hs_q, vs_q, hs_d, vs_d, v_restart;
    logic [CNT_W-1:0] hcnt_q, vcnt_q;
    // a vsync edge restarts line numbering at the next hsync edge, or at once when both coincide
    always_comb begin
        hs_edge = (hs_q == SYNC_POL) && (hs_d != SYNC_POL);
        vs_edge = (vs_q == SYNC_POL) && (vs_d != SYNC_POL);
        h_meas  = &hcnt_q ? hcnt_q : hcnt_q + 1'b1;
        v_meas  = &vcnt_q ? vcnt_q : vcnt_q + 1'b1;
        hpos    = hs_edge ? '0 : h_meas;
        vpos    = !hs_edge ? vcnt_q : (vs_edge || v_restart) ? '0 : v_meas;
    end
    always_ff @(posedge vdu_clk) begin
        if (vdu_rst) begin
            {rgb, hs_q, vs_q, hs_d, vs_d, v_restart} <= '0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            h_total <= '0;
            v_total <= '0;
        end else begin
            rgb       <= {red, green, blue};
            hs_q      <= horiz_sync;
            vs_q      <= vert_sync;
            hs_d      <= hs_q;
            vs_d      <= vs_q;
            hcnt_q    <= hpos;
            vcnt_q    <= vpos;
            v_restart <= hs_edge ? 1'b0 : (vs_edge | v_restart);
            h_total   <= hs_edge ? h_meas : h_total;
            v_total   <= vs_edge ? v_meas : v_total;
        end
    end
endmodule

// File: rtl/vdu_capture.sv
// vdu_capture: locks to incoming RGB/sync timing and writes one active frame into pixel memory
// ports: vdu_clk/vdu_rst; vga_*_i colour and horiz_sync/vert_sync inputs; cap_en capture request;
//        wr_en/wr_addr/wr_data pixel write port; frame_done completion pulse; locked; h_total/v_total; err sticky
module vdu_capture import vdu_pkg::*; #(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   H_START  = DEF_H_START,
    parameter int   V_START  = DEF_V_START,
    parameter logic SYNC_POL = DEF_SYNC_POL,
    parameter int   CNT_W    = 10,
    parameter int   ADDR_W   = 19
) (
    input  logic              vdu_clk,
    input  logic              vdu_rst,
    input  logic              vga_red_i,
    input  logic              vga_green_i,
    input  logic              vga_blue_i,
    input  logic              horiz_sync,
    input  logic              vert_sync,
    input  logic              cap_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic              frame_done,
    output logic              locked,
    output logic [CNT_W-1:0]  h_total,
    output logic [CNT_W-1:0]  v_total,
    output logic              err
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [CNT_W-1:0]  H_LO = CNT_W'(H_START);
    localparam logic [CNT_W-1:0]  H_HI = CNT_W'(H_START + H_ACTIVE);
    localparam logic [CNT_W-1:0]  V_LO = CNT_W'(V_START);
    localparam logic [CNT_W-1:0]  V_HI = CNT_W'(V_START + V_ACTIVE);
    lock_state_t state_q, state_d;
    logic [2:0] rgb;
    logic hs_edge, vs_edge, armed, lose, arm, active, last_wr;
    logic [CNT_W-1:0] hpos, vpos, h_meas, v_meas, ref_h, ref_v;
    vdu_sync_meas #(.SYNC_POL(SYNC_POL), .CNT_W(CNT_W)) u_meas (
        .vdu_clk(vdu_clk), .vdu_rst(vdu_rst),
        .red(vga_red_i), .green(vga_green_i), .blue(vga_blue_i),
        .horiz_sync(horiz_sync), .vert_sync(vert_sync),
        .rgb(rgb), .hs_edge(hs_edge), .vs_edge(vs_edge),
        .hpos(hpos), .vpos(vpos), .h_meas(h_meas), .v_meas(v_meas),
        .h_total(h_total), .v_total(v_total)
    );
    always_comb begin
        lose    = (state_q == LOCKED) && ((hs_edge && h_meas != ref_h) || (vs_edge && v_meas != ref_v));
        arm     = (state_q == LOCKED) && vs_edge && cap_en && !lose;
        active  = armed && hpos >= H_LO && hpos < H_HI && vpos >= V_LO && vpos < V_HI;
        last_wr = wr_en && wr_addr == LAST;
        state_d = state_q;
        if (state_q == UNLOCKED && vs_edge) state_d = TRACK;
        if (state_q == TRACK && vs_edge && h_total == ref_h && v_meas == ref_v) state_d = LOCKED;
        if (lose) state_d = UNLOCKED;
    end
    always_ff @(posedge vdu_clk) begin
        if (vdu_rst) state_q <= UNLOCKED;
        else         state_q <= state_d;
    end
    // references are cleared when tracking restarts so recovery always needs three clean frames
    always_ff @(posedge vdu_clk) begin
        if (vdu_rst) begin
            {ref_h, ref_v} <= '0;
            {armed, wr_en, frame_done, locked, err} <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            ref_h      <= !vs_edge ? ref_h : (state_q == UNLOCKED) ? '0 : (state_q == TRACK) ? h_total : ref_h;
            ref_v      <= !vs_edge ? ref_v : (state_q == UNLOCKED) ? '0 : (state_q == TRACK) ? v_meas : ref_v;
            locked     <= state_d == LOCKED;
            armed      <= arm | (armed & !lose & !last_wr);
            wr_en      <= active & !lose;
            wr_data    <= active ? rgb : wr_data;
            wr_addr    <= arm ? '0 : wr_addr + ADDR_W'(wr_en);
            frame_done <= last_wr & !lose;
            err        <= err | lose;
        end
    end
endmodule

// File: tb/tb_vdu_capture.sv
// tb_vdu_capture: directed checks of lock, capture, cap_en timing, disturbance and reset on a 16x10 raster
module tb_vdu_capture;
    localparam int H_TOT = 16, V_TOT = 10, HA = 8, VA = 4, HS = 4, VS = 2, NPIX = HA * VA;
    logic vdu_clk = 1'b0, vdu_rst = 1'b1;
    logic vga_red_i = 1'b0, vga_green_i = 1'b0, vga_blue_i = 1'b0;
    logic horiz_sync = 1'b1, vert_sync = 1'b1, cap_en = 1'b0;
    logic wr_en, frame_done, locked, err;
    logic [18:0] wr_addr;
    logic [2:0] wr_data;
    logic [9:0] h_total, v_total;
    int total = 0, bad = 0;
    int cyc = 0, nwr = 0, nbad_addr = 0, nbad_data = 0, ndone = 0;
    int last_addr = -1, first_wr_cyc = -1, lock_rise_cyc = -1, vs_cyc = 0, pix_cyc = 0;
    logic [2:0] first_data = '0;
    logic prev_locked = 1'b0;

    vdu_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_START(HS), .V_START(VS),
                  .SYNC_POL(1'b0), .CNT_W(10), .ADDR_W(19)) dut (
        .vdu_clk(vdu_clk), .vdu_rst(vdu_rst),
        .vga_red_i(vga_red_i), .vga_green_i(vga_green_i), .vga_blue_i(vga_blue_i),
        .horiz_sync(horiz_sync), .vert_sync(vert_sync), .cap_en(cap_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
        .locked(locked), .h_total(h_total), .v_total(v_total), .err(err)
    );

    always #5 vdu_clk = ~vdu_clk;
    always @(posedge vdu_clk) cyc <= cyc + 1;

    always @(negedge vdu_clk) begin
        if (wr_en) begin
            nwr <= nwr + 1;
            if (wr_addr != 0 && int'(wr_addr) != last_addr + 1) nbad_addr <= nbad_addr + 1;
            if (wr_data != 3'((int'(wr_addr) % HA + HS) % 8)) nbad_data <= nbad_data + 1;
            if (wr_addr == 0) begin
                first_wr_cyc <= cyc;
                first_data <= wr_data;
            end
            last_addr <= int'(wr_addr);
        end
        if (frame_done) ndone <= ndone + 1;
        if (locked && !prev_locked) lock_rise_cyc <= cyc;
        prev_locked <= locked;
    end

    task automatic drive_frame(input int long_line, input bit cap0, input bit cap1, input int stop_addr, output bit hit);
        hit = 1'b0;
        for (int l = 0; l < V_TOT; l++) begin
            cap_en = (l < 5) ? cap0 : cap1;
            for (int i = 0; i < ((l == long_line) ? H_TOT + 1 : H_TOT); i++) begin
                @(negedge vdu_clk);
                if (stop_addr >= 0 && wr_en && int'(wr_addr) == stop_addr) begin
                    hit = 1'b1;
                    return;
                end
                horiz_sync = (i < 2) ? 1'b0 : 1'b1;
                vert_sync = (l < 2) ? 1'b0 : 1'b1;
                {vga_red_i, vga_green_i, vga_blue_i} = i[2:0];
                if (l == 0 && i == 0) vs_cyc = cyc;
                if (l == VS && i == HS) pix_cyc = cyc;
            end
        end
    endtask

    task automatic test_reset;
        int w0;
        vdu_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            {vga_red_i, vga_green_i, vga_blue_i, horiz_sync, vert_sync, cap_en} = 6'($urandom);
            @(negedge vdu_clk);
        end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
        total++; if (wr_addr !== '0) begin bad++; $display("FAIL rst_wr_addr got=%0d exp=0", wr_addr); end
        total++; if (wr_data !== '0) begin bad++; $display("FAIL rst_wr_data got=%0d exp=0", wr_data); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%b exp=0", locked); end
        total++; if (h_total !== '0) begin bad++; $display("FAIL rst_h_total got=%0d exp=0", h_total); end
        total++; if (v_total !== '0) begin bad++; $display("FAIL rst_v_total got=%0d exp=0", v_total); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
        horiz_sync = 1'b1; vert_sync = 1'b1; cap_en = 1'b1;
        {vga_red_i, vga_green_i, vga_blue_i} = 3'b111;
        vdu_rst = 1'b0;
        w0 = nwr;
        repeat (40) @(negedge vdu_clk);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL static_locked got=%b exp=0", locked); end
        total++; if (nwr - w0 != 0) begin bad++; $display("FAIL static_writes got=%0d exp=0", nwr - w0); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL static_err got=%b exp=0", err); end
    endtask

    task automatic test_lock;
        bit hit;
        drive_frame(-1, 1'b0, 1'b0, -1, hit);
        drive_frame(-1, 1'b0, 1'b0, -1, hit);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_early got=%b exp=0", locked); end
        drive_frame(-1, 1'b0, 1'b0, -1, hit);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_locked got=%b exp=1", locked); end
        total++; if (lock_rise_cyc != vs_cyc + 2) begin bad++; $display("FAIL lock_rise_time got=%0d exp=%0d", lock_rise_cyc, vs_cyc + 2); end
        total++; if (h_total !== 10'(H_TOT)) begin bad++; $display("FAIL lock_h_total got=%0d exp=%0d", h_total, H_TOT); end
        total++; if (v_total !== 10'(V_TOT)) begin bad++; $display("FAIL lock_v_total got=%0d exp=%0d", v_total, V_TOT); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL lock_err got=%b exp=0", err); end
    endtask

    task automatic test_capture;
        bit hit;
        int w0, a0, d0, f0;
        w0 = nwr; a0 = nbad_addr; d0 = nbad_data; f0 = ndone;
        drive_frame(-1, 1'b1, 1'b0, -1, hit);
        total++; if (nwr - w0 != NPIX) begin bad++; $display("FAIL cap_writes got=%0d exp=%0d", nwr - w0, NPIX); end
        total++; if (nbad_addr - a0 != 0) begin bad++; $display("FAIL cap_addr_gaps got=%0d exp=0", nbad_addr - a0); end
        total++; if (nbad_data - d0 != 0) begin bad++; $display("FAIL cap_data_errs got=%0d exp=0", nbad_data - d0); end
        total++; if (last_addr != NPIX - 1) begin bad++; $display("FAIL cap_last_addr got=%0d exp=%0d", last_addr, NPIX - 1); end
        total++; if (first_wr_cyc - pix_cyc != 2) begin bad++; $display("FAIL cap_latency got=%0d exp=2", first_wr_cyc - pix_cyc); end
        total++; if (first_data !== 3'(HS % 8)) begin bad++; $display("FAIL cap_first_data got=%0d exp=%0d", first_data, HS % 8); end
        total++; if (ndone - f0 != 1) begin bad++; $display("FAIL cap_frame_done got=%0d exp=1", ndone - f0); end
        w0 = nwr; f0 = ndone;
        drive_frame(-1, 1'b0, 1'b0, -1, hit);
        total++; if (nwr - w0 != 0) begin bad++; $display("FAIL cap_unarmed_writes got=%0d exp=0", nwr - w0); end
        total++; if (ndone - f0 != 0) begin bad++; $display("FAIL cap_unarmed_done got=%0d exp=0", ndone - f0); end
    endtask

    task automatic test_cap_en_timing;
        bit hit;
        int w0, f0;
        w0 = nwr;
        drive_frame(-1, 1'b0, 1'b1, -1, hit);
        total++; if (nwr - w0 != 0) begin bad++; $display("FAIL capen_mid_writes got=%0d exp=0", nwr - w0); end
        w0 = nwr; f0 = ndone;
        drive_frame(-1, 1'b1, 1'b1, -1, hit);
        total++; if (nwr - w0 != NPIX) begin bad++; $display("FAIL capen_next_writes got=%0d exp=%0d", nwr - w0, NPIX); end
        total++; if (ndone - f0 != 1) begin bad++; $display("FAIL capen_next_done got=%0d exp=1", ndone - f0); end
    endtask

    task automatic test_disturb;
        bit hit;
        int w0, f0;
        w0 = nwr; f0 = ndone;
        drive_frame(4, 1'b1, 1'b1, -1, hit);
        total++; if (nwr - w0 != 3 * HA) begin bad++; $display("FAIL dist_writes got=%0d exp=%0d", nwr - w0, 3 * HA); end
        total++; if (ndone - f0 != 0) begin bad++; $display("FAIL dist_done got=%0d exp=0", ndone - f0); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL dist_locked got=%b exp=0", locked); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL dist_err got=%b exp=1", err); end
        drive_frame(-1, 1'b0, 1'b0, -1, hit);
        drive_frame(-1, 1'b0, 1'b0, -1, hit);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL recov_early got=%b exp=0", locked); end
        drive_frame(-1, 1'b0, 1'b0, -1, hit);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL recov_locked got=%b exp=1", locked); end
        total++; if (lock_rise_cyc != vs_cyc + 2) begin bad++; $display("FAIL recov_rise_time got=%0d exp=%0d", lock_rise_cyc, vs_cyc + 2); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL recov_err got=%b exp=1", err); end
    endtask

    task automatic test_reset_mid;
        bit hit;
        drive_frame(-1, 1'b1, 1'b1, 10, hit);
        total++; if (hit !== 1'b1) begin bad++; $display("FAIL midrst_reach got=%b exp=1", hit); end
        vdu_rst = 1'b1;
        @(posedge vdu_clk);
        @(negedge vdu_clk);
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL midrst_wr_en got=%b exp=0", wr_en); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL midrst_locked got=%b exp=0", locked); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b exp=0", err); end
        total++; if (wr_addr !== '0) begin bad++; $display("FAIL midrst_wr_addr got=%0d exp=0", wr_addr); end
        vdu_rst = 1'b0;
    endtask

    initial begin
        test_reset;
        test_lock;
        test_capture;
        test_cap_en_timing;
        test_disturb;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
